// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the icache (read-only)
// and the dcache (read/write), with fixed read/write latencies and a one-cycle done pulse.
//
// state  | meaning
// IDLE   | waiting for i_req/d_req, grants on the edge leaving this state
// ACCESS | mem_en held with latched address/we/wdata for LAT cycles
// DONE   | done pulse to the granted requester, last_grant updated
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 4,
  parameter int WR_LATENCY = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_LATENCY - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          gnt_d;
  logic          last_d;
  logic          pick_d;

  // On a tie the requester that was not served last wins.
  assign pick_d = d_req & (~i_req | ~last_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      gnt_d     <= 1'b0;
      last_d    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req | d_req) begin
            gnt_d  <= pick_d;
            mem_en <= 1'b1;
            busy   <= 1'b1;
            state  <= ACCESS;
            if (pick_d) begin
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
              cnt       <= d_we ? WR_LOAD : RD_LOAD;
            end else begin
              mem_addr  <= i_addr;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
              cnt       <= RD_LOAD;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            state  <= DONE;
            // mem_we still holds the latched direction of this transfer
            if (!mem_we) begin
              if (gnt_d) d_rdata <= mem_rdata;
              else       i_rdata <= mem_rdata;
            end
            if (gnt_d) d_done <= 1'b1;
            else       i_done <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          last_d <= gnt_d;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a timestamp-based transaction model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic          i_done, d_done, mem_en, mem_we, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    logic [127:0] got;
    idle_inputs;
    reset = 1'b1;
    tick; tick;
    got = {i_rdata, d_rdata, i_done, d_done, mem_en, mem_we, mem_addr, mem_wdata, busy};
    n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL reset_outputs_in_reset: got %h want 0", got); end
    reset = 1'b0;
    tick;
    got = {i_rdata, d_rdata, i_done, d_done, mem_en, mem_we, mem_addr, mem_wdata, busy};
    n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL reset_outputs_idle: got %h want 0", got); end
  endtask

  task automatic test_icache_read;
    logic [127:0] got, want;
    do_reset;
    i_req = 1'b1; i_addr = 32'h0000_1000; mem_rdata = 32'hDEAD_BEEF;
    for (int k = 1; k <= RD_LAT; k++) begin
      tick;
      got  = {mem_en, mem_we, mem_addr, busy, i_done, d_done, i_rdata};
      want = {1'b1, 1'b0, 32'h0000_1000, 1'b1, 1'b0, 1'b0, 32'h0};
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL icache_access cyc %0d: got %h want %h", k, got, want); end
    end
    tick;
    got  = {i_done, d_done, mem_en, busy, i_rdata};
    want = {1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL icache_done: got %h want %h", got, want); end
    i_req = 1'b0;
    tick;
    got  = {i_done, d_done, busy, i_rdata};
    want = {1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL icache_after: got %h want %h", got, want); end
  endtask

  task automatic test_dcache_write;
    logic [127:0] got, want;
    do_reset;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2004; d_wdata = 32'h1234_5678;
    mem_rdata = 32'hFFFF_0000;
    for (int k = 1; k <= WR_LAT; k++) begin
      tick;
      got  = {mem_en, mem_we, mem_addr, mem_wdata, d_done, i_done, busy};
      want = {1'b1, 1'b1, 32'h0000_2004, 32'h1234_5678, 1'b0, 1'b0, 1'b1};
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL dwrite_access cyc %0d: got %h want %h", k, got, want); end
    end
    tick;
    got  = {d_done, i_done, mem_en, mem_we, d_rdata};
    want = {1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL dwrite_done: got %h want %h", got, want); end
    d_req = 1'b0; d_we = 1'b0;
    tick;
    got  = {d_done, busy, d_rdata};
    want = {1'b0, 1'b0, 32'h0};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL dwrite_after: got %h want %h", got, want); end
  endtask

  task automatic test_tie;
    logic [127:0] got, want;
    logic [31:0]  exp_addr, exp_data;
    logic         gd;
    do_reset;
    i_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int n = 0; n < 4; n++) begin
      gd = (n % 2 == 0);
      exp_addr = gd ? 32'h200 : 32'h100;
      exp_data = 32'hC0DE_0000 + 32'(n);
      mem_rdata = exp_data;
      for (int k = 1; k <= RD_LAT; k++) begin
        tick;
        got  = {mem_en, mem_addr, i_done, d_done};
        want = {1'b1, exp_addr, 1'b0, 1'b0};
        n_checks++;
        if (got !== want) begin n_fail++; $display("FAIL tie_access n%0d cyc %0d: got %h want %h", n, k, got, want); end
      end
      tick;
      got  = {i_done, d_done, gd ? d_rdata : i_rdata};
      want = {~gd, gd, exp_data};
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL tie_done n%0d: got %h want %h", n, got, want); end
      if (n == 3) begin i_req = 1'b0; d_req = 1'b0; end
      tick;
      got  = {busy, mem_en, i_done, d_done};
      want = '0;
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL tie_idle n%0d: got %h want %h", n, got, want); end
    end
    tick;
    n_checks++;
    if (mem_en !== 1'b0) begin n_fail++; $display("FAIL tie_no_extra_grant: got %b want 0", mem_en); end
  endtask

  task automatic test_late_arrival;
    logic [127:0] got, want;
    do_reset;
    mem_rdata = 32'h1111_2222;
    d_we = 1'b0; d_addr = 32'h300; d_req = 1'b1;
    for (int k = 1; k <= RD_LAT; k++) begin
      tick;
      got  = {mem_en, mem_addr, i_done};
      want = {1'b1, 32'h300, 1'b0};
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL late_daccess cyc %0d: got %h want %h", k, got, want); end
      if (k == 2) begin i_addr = 32'h400; i_req = 1'b1; end
    end
    tick;
    got  = {d_done, i_done};
    want = {1'b1, 1'b0};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL late_ddone: got %h want %h", got, want); end
    d_req = 1'b0;
    tick;
    got  = {busy, mem_en, i_done};
    want = '0;
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL late_idle: got %h want %h", got, want); end
    for (int k = 1; k <= RD_LAT; k++) begin
      tick;
      got  = {mem_en, mem_we, mem_addr, i_done};
      want = {1'b1, 1'b0, 32'h400, 1'b0};
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL late_iaccess cyc %0d: got %h want %h", k, got, want); end
    end
    tick;
    got  = {i_done, i_rdata};
    want = {1'b1, 32'h1111_2222};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL late_idone: got %h want %h", got, want); end
    i_req = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_access;
    logic [127:0] got, want;
    i_addr = 32'h500; i_req = 1'b1; mem_rdata = 32'h3333_4444;
    tick;
    n_checks++;
    if (mem_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_started: got %b want 1", mem_en); end
    tick;
    reset = 1'b1; i_req = 1'b0;
    tick;
    got  = {mem_en, busy, i_done, i_rdata};
    want = '0;
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rstmid_aborted: got %h want %h", got, want); end
    reset = 1'b0; i_addr = 32'h600; i_req = 1'b1; mem_rdata = 32'h5555_6666;
    for (int k = 1; k <= RD_LAT; k++) begin
      tick;
      got  = {mem_en, mem_addr, i_done};
      want = {1'b1, 32'h600, 1'b0};
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL rstmid_fresh cyc %0d: got %h want %h", k, got, want); end
    end
    tick;
    got  = {i_done, i_rdata};
    want = {1'b1, 32'h5555_6666};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rstmid_fresh_done: got %h want %h", got, want); end
    i_req = 1'b0;
    tick;
  endtask

  task automatic test_req_drop;
    logic [127:0] got, want;
    d_we = 1'b0; d_addr = 32'h700; d_req = 1'b1; mem_rdata = 32'hA5A5_5A5A;
    for (int k = 1; k <= RD_LAT; k++) begin
      tick;
      if (k == 1) d_req = 1'b0;
      got  = {mem_en, mem_addr, d_done};
      want = {1'b1, 32'h700, 1'b0};
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL drop_access cyc %0d: got %h want %h", k, got, want); end
    end
    tick;
    got  = {d_done, busy, d_rdata};
    want = {1'b1, 1'b1, 32'hA5A5_5A5A};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL drop_done: got %h want %h", got, want); end
    tick;
    tick;
    got  = {mem_en, busy, d_done};
    want = '0;
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL drop_no_regrant: got %h want %h", got, want); end
  endtask

  // Transaction model: a grant at cycle s with latency L means mem_en in s+1..s+L,
  // done at s+L+1 and the arbiter free again from s+L+2.
  task automatic test_random;
    int           s, L, next_idle;
    bit           act, g, last_d_m, a_we, exp_en, exp_done, exp_busy;
    logic [31:0]  a_addr, a_wdata, cap, exp_ir, exp_dr;
    logic [127:0] got, want;
    idle_inputs;
    do_reset;
    s = 0; L = 0; next_idle = 0; act = 0; g = 0; last_d_m = 0; a_we = 0;
    a_addr = '0; a_wdata = '0; cap = '0; exp_ir = '0; exp_dr = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) tick;
      if (act && c == s + L + 1 && !a_we) begin
        if (g) exp_dr = cap;
        else   exp_ir = cap;
      end
      exp_en   = act && c >= s + 1 && c <= s + L;
      exp_done = act && c == s + L + 1;
      exp_busy = act && c >= s + 1;
      got  = {mem_en, busy, i_done, d_done, i_rdata, d_rdata};
      want = {exp_en, exp_busy, exp_done && !g, exp_done && g, exp_ir, exp_dr};
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL rand_ctrl cyc %0d: got %h want %h", c, got, want); end
      if (exp_en) begin
        got  = {mem_we, mem_addr, a_we ? mem_wdata : 32'h0};
        want = {a_we, a_addr, a_we ? a_wdata : 32'h0};
        n_checks++;
        if (got !== want) begin n_fail++; $display("FAIL rand_bus cyc %0d: got %h want %h", c, got, want); end
      end
      if (exp_done) begin
        last_d_m = g; act = 0; next_idle = c + 1;
        if (g) d_req = 1'b0;
        else   i_req = 1'b0;
      end else if (act && c >= s + 1) begin
        if (g) begin
          d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 15) == 0) d_req = 1'b0;
        end else begin
          i_addr = $urandom;
          if ($urandom_range(0, 15) == 0) i_req = 1'b0;
        end
      end
      if (!i_req && !(exp_done && !g) && $urandom_range(0, 3) == 0) begin
        i_req = 1'b1; i_addr = $urandom;
      end
      if (!d_req && !(exp_done && g) && $urandom_range(0, 3) == 0) begin
        d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
      end
      mem_rdata = $urandom;
      if (act && c == s + L) cap = mem_rdata;
      if (!act && c >= next_idle && (i_req || d_req)) begin
        g       = d_req && (!i_req || !last_d_m);
        act     = 1;
        s       = c;
        a_we    = g ? d_we : 1'b0;
        a_addr  = g ? d_addr : i_addr;
        a_wdata = d_wdata;
        L       = a_we ? WR_LAT : RD_LAT;
      end
    end
    idle_inputs;
    for (int k = 0; k < 10; k++) tick;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_icache_read;
    test_dcache_write;
    test_tie;
    test_late_arrival;
    test_reset_mid_access;
    test_req_drop;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
